// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side engine: FSM encoding, default width, occupancy helper.
package fifo_pkg;

  localparam int DEF_DW = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_STREAM = S_STREAM,
    ST_HOLD   = S_HOLD
  } state_t;

  // Words that will be held after this cycle: skid entries plus the word in flight, minus the one leaving.
  function automatic logic [2:0] next_level(input logic [1:0] occ, input logic infl, input logic xfer);
    return {1'b0, occ} + {2'b00, infl} - {2'b00, xfer};
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus downstream valid/ready stream, seen by the read engine (master) and its environment (slave).
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DW = DEF_DW
);
  logic          fifo_empty;
  logic          fifo_aempty;
  logic [DW-1:0] fifo_dout;
  logic          rd;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (
    input  fifo_empty, fifo_aempty, fifo_dout, m_ready,
    output rd, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_aempty, fifo_dout, m_ready,
    input  rd, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_ctrl_chk.sv
// Simulation checker: the pop rule must never let a capture land on a full skid buffer.
module fifo_rd_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       push,
  input logic       pop,
  input logic [1:0] occ
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && (occ == 2'd2)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && (occ == 2'd0)));

endmodule

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer; entry 0 is the head and drives the output word directly from a flop.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [1:0]    occ,
  output logic          valid,
  output logic [DW-1:0] head
);

  logic [DW-1:0] e0_r;
  logic [DW-1:0] e1_r;
  logic [1:0]    occ_r;

  // Entry and occupancy update; a simultaneous push and pop keeps occupancy and shifts in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_r  <= '0;
      e1_r  <= '0;
      occ_r <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          case (occ_r)
            2'd0:    e0_r <= din;
            2'd1:    e1_r <= din;
            default: e1_r <= e1_r;
          endcase
          if (occ_r != 2'd2) begin
            occ_r <= occ_r + 2'd1;
          end else begin
            occ_r <= occ_r;
          end
        end
        2'b01: begin
          e0_r <= e1_r;
          if (occ_r != 2'd0) begin
            occ_r <= occ_r - 2'd1;
          end else begin
            occ_r <= occ_r;
          end
        end
        2'b11: begin
          case (occ_r)
            2'd2: begin
              e0_r <= e1_r;
              e1_r <= din;
            end
            2'd1:    e0_r <= din;
            default: begin
              e0_r  <= din;
              occ_r <= 2'd1;
            end
          endcase
        end
        default: begin
          e0_r  <= e0_r;
          e1_r  <= e1_r;
          occ_r <= occ_r;
        end
      endcase
    end
  end

  assign occ   = occ_r;
  assign valid = (occ_r != 2'd0);
  assign head  = e0_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side engine: pops the flagged sync FIFO and streams words out on valid/ready through a skid buffer.
// Optional popped-word counter enabled by `FIFO_RD_CTRL_STATS_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DW = DEF_DW
`ifdef FIFO_RD_CTRL_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  fifo_rd_ctrl_if.master    bus,
  output logic              busy
`ifdef FIFO_RD_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  pop_cnt
`endif
);

  state_t        state_r;
  logic          infl_r;
  logic [1:0]    occ_s;
  logic          valid_s;
  logic [DW-1:0] head_s;
  logic          xfer_s;
  logic [2:0]    level_s;
  logic          rd_s;

  assign xfer_s  = valid_s && bus.m_ready;
  assign level_s = next_level(occ_s, infl_r, xfer_s);

  // EMPTY lags a cycle, so a pop right behind a pop is refused once ALMOST_EMPTY says at most one word was left.
  always_comb begin
    rd_s = 1'b0;
    if (!bus.fifo_empty && (level_s < 3'd2) && !(infl_r && bus.fifo_aempty)) begin
      rd_s = 1'b1;
    end else begin
      rd_s = 1'b0;
    end
  end

  assign bus.rd      = rd_s;
  assign bus.m_valid = valid_s;
  assign bus.m_data  = head_s;
  assign busy        = (state_r != ST_IDLE);

  fifo_skid_buf #(.DW(DW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_r),
    .pop   (xfer_s),
    .din   (bus.fifo_dout),
    .occ   (occ_s),
    .valid (valid_s),
    .head  (head_s)
  );

  fifo_rd_ctrl_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (infl_r),
    .pop  (xfer_s),
    .occ  (occ_s)
  );

  // In-flight tracking and stream state; reset drops whatever was in flight without re-issuing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      infl_r  <= 1'b0;
    end else begin
      infl_r <= rd_s;
      case (state_r)
        ST_IDLE: begin
          if (rd_s) begin
            state_r <= ST_STREAM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_STREAM: begin
          if ((occ_s == 2'd2) && !bus.m_ready) begin
            state_r <= ST_HOLD;
          end else if ((level_s == 3'd0) && !rd_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_STREAM;
          end
        end
        ST_HOLD: begin
          if (bus.m_ready) begin
            state_r <= ST_STREAM;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_CTRL_STATS_EN
  // Popped-word counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt <= '0;
    end else if (rd_s) begin
      pop_cnt <= pop_cnt + CNT_W'(1);
    end else begin
      pop_cnt <= pop_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: drives a behavioural flagged sync FIFO (flags lag count by one clock) and scoreboards the stream.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.DW(8)) bus ();
  logic busy;
`ifdef FIFO_RD_CTRL_STATS_EN
  logic [15:0] pop_cnt;
`endif

  fifo_rd_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy)
`ifdef FIFO_RD_CTRL_STATS_EN
    ,
    .pop_cnt (pop_cnt)
`endif
  );

  // behavioural FIFO
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] mem [0:255];
  logic [7:0] wp, rp;
  int         cnt;
  logic       f_empty, f_aempty;
  logic [7:0] f_dout;
  int         underflow_cnt = 0;

  assign bus.fifo_empty  = f_empty;
  assign bus.fifo_aempty = f_aempty;
  assign bus.fifo_dout   = f_dout;

  always @(posedge clk) begin
    if (rst) begin
      cnt      <= 0;
      wp       <= 8'd0;
      rp       <= 8'd0;
      f_empty  <= 1'b1;
      f_aempty <= 1'b1;
      f_dout   <= 8'd0;
    end else begin
      if (wr) begin
        mem[wp] <= wdata;
        wp      <= wp + 8'd1;
      end
      if (bus.rd) begin
        if (cnt == 0) underflow_cnt = underflow_cnt + 1;
        f_dout <= mem[rp];
        rp     <= rp + 8'd1;
      end
      cnt      <= cnt + (wr ? 1 : 0) - (bus.rd ? 1 : 0);
      f_empty  <= (cnt == 0);
      f_aempty <= (cnt <= 1);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard and monitor
  logic [7:0] q[$];
  logic [7:0] exp_d;
  int cyc = 0;
  int pops = 0;
  int rd_empty_cnt = 0;
  int hold_err = 0;
  int win_pops, win_valid, win_xfer;
  int first_xfer, last_xfer, first_rd, first_valid;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.rd) begin
        win_pops++;
        pops++;
        if (first_rd < 0) first_rd = cyc;
        if (f_empty) rd_empty_cnt++;
      end
      if (bus.m_valid) begin
        win_valid++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (prev_valid && !prev_ready && (!bus.m_valid || (bus.m_data != prev_data))) hold_err++;
      if (bus.m_valid && bus.m_ready) begin
        win_xfer++;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        if (q.size() == 0) begin
          check("extra_word", q.size(), 1);
        end else begin
          exp_d = q.pop_front();
          check("data", bus.m_data, exp_d);
        end
      end
      prev_valid = bus.m_valid;
      prev_ready = bus.m_ready;
      prev_data  = bus.m_data;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_win();
    win_pops = 0; win_valid = 0; win_xfer = 0;
    first_xfer = -1; last_xfer = -1; first_rd = -1; first_valid = -1;
  endtask

  task automatic push_word(input logic [7:0] d);
    wr = 1'b1;
    wdata = d;
    q.push_back(d);
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((q.size() != 0 || busy || !f_empty || bus.m_valid) && n < budget) begin
      tick();
      n++;
    end
    check(tag, {q.size() != 0, busy, !f_empty, bus.m_valid}, 4'b0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int n;
    wr = 1'b0;
    wdata = 8'd0;
    bus.m_ready = 1'b0;
    clear_win();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // 1: idle after reset
    repeat (20) tick();
    check("t1_rd", bus.rd, 1'b0);
    check("t1_valid", bus.m_valid, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_data", bus.m_data, 8'h00);
    check("t1_pops", win_pops, 0);
`ifdef FIFO_RD_CTRL_STATS_EN
    check("t1_pop_cnt", pop_cnt, 16'd0);
`endif

    // 2: single word
    bus.m_ready = 1'b1;
    clear_win();
    push_word(8'hA5);
    wait_drain(50, "t2_drain");
    check("t2_pops", win_pops, 1);
    check("t2_valid_cycles", win_valid, 1);
    check("t2_xfers", win_xfer, 1);
    check("t2_latency", first_valid - first_rd, 2);

    // 3: eight words, consumer always ready
    clear_win();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    wait_drain(100, "t3_drain");
    check("t3_xfers", win_xfer, 8);
    check("t3_back_to_back", last_xfer - first_xfer, 7);

    // 4: eight words with a ten-clock stall
    bus.m_ready = 1'b0;
    clear_win();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    repeat (2) tick();
    check("t4_stall_pops", win_pops, 2);
    check("t4_busy", busy, 1'b1);
    check("t4_rd", bus.rd, 1'b0);
    check("t4_valid", bus.m_valid, 1'b1);
    check("t4_head", bus.m_data, 8'h01);
    bus.m_ready = 1'b1;
    wait_drain(100, "t4_drain");
    check("t4_xfers", win_xfer, 8);

    // 5: random backpressure over 200 words
    clear_win();
    sent = 0;
    n = 0;
    while (sent < 200 && n < 5000) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        wr = 1'b1;
        wdata = 8'($urandom);
        q.push_back(wdata);
        sent++;
      end else begin
        wr = 1'b0;
      end
      tick();
      n++;
    end
    wr = 1'b0;
    bus.m_ready = 1'b1;
    wait_drain(2000, "t5_drain");
    check("t5_xfers", win_xfer, 200);
    check("t5_underflow", underflow_cnt, 0);
`ifdef FIFO_RD_CTRL_STATS_EN
    check("t5_pop_cnt", pop_cnt, 16'(pops));
`endif

    // 6: reset mid-stream with a word buffered and one in flight
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
    check("t6_pre_valid", bus.m_valid, 1'b1);
    rst = 1'b1;
    tick();
    q.delete();
    pops = 0;
    check("t6_rd", bus.rd, 1'b0);
    check("t6_valid", bus.m_valid, 1'b0);
    check("t6_data", bus.m_data, 8'h00);
    check("t6_busy", busy, 1'b0);
`ifdef FIFO_RD_CTRL_STATS_EN
    check("t6_pop_cnt", pop_cnt, 16'd0);
`endif
    rst = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    clear_win();
    for (int i = 1; i <= 3; i++) push_word(8'hC0 + 8'(i));
    wait_drain(100, "t6_drain");
    check("t6_xfers", win_xfer, 3);

    check("rd_while_empty", rd_empty_cnt, 0);
    check("fifo_underflow", underflow_cnt, 0);
    check("hold_stability", hold_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
